// File: rtl/ii_window_fetch_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ii_window_fetch_arbiter_pkg
//   Shared constants and types for the integral-image window fetch arbiter:
//   image geometry, bus widths, FSM state encoding, corner indices, the
//   read-tag record carried alongside frame_buffer reads, and the
//   multiply-free row offset helper used for address generation.
// ----------------------------------------------------------------------------
package ii_window_fetch_arbiter_pkg;

    localparam int IMG_W  = 160;  // row stride of the integral image
    localparam int IMG_H  = 120;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 12;   // all sums wrap modulo 2^DATA_W

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Corner indices double as issue priority: lower index is read first.
    localparam logic [1:0] CORNER_D = 2'd0;  // (x1, y1)
    localparam logic [1:0] CORNER_C = 2'd1;  // (x0, y1)
    localparam logic [1:0] CORNER_B = 2'd2;  // (x1, y0)
    localparam logic [1:0] CORNER_A = 2'd3;  // (x0, y0)

    // Travels with every frame_buffer read so returning data can be routed.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } tag_t;

    // row * 160 as (row << 7) + (row << 5); tied to IMG_W == 160.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [ADDR_W-1:0] row);
        return (row << 7) + (row << 5);
    endfunction

endpackage

// File: rtl/ii_corner_addr.sv
// ----------------------------------------------------------------------------
// ii_corner_addr
//   Registered address generator for the window's bottom-right corner (D)
//   plus the row span used to reach the top corners, and flags marking the
//   corners that fall outside the image (row -1 / column -1) and read as zero.
//   Loads only while en_i is high and holds its outputs otherwise.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   en_i          load strobe (arbiter in CALC)
//   x_i, y_i      coordinates of corner D (x1, y1)
//   h_i           window height, converted to a row span
//   left_i        window starts at column 0 -> corners A and C are zero
//   top_i         window starts at row 0    -> corners A and B are zero
//   addr_o        y_i * IMG_W + x_i
//   span_o        h_i * IMG_W
//   zero_*_o      corner is implicitly zero and must not be read
// ----------------------------------------------------------------------------
module ii_corner_addr
    import ii_window_fetch_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [7:0]        x_i,
    input  logic [6:0]        y_i,
    input  logic [6:0]        h_i,
    input  logic              left_i,
    input  logic              top_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] span_o,
    output logic              zero_a_o,
    output logic              zero_b_o,
    output logic              zero_c_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] span_q;
    logic              zero_a_q;
    logic              zero_b_q;
    logic              zero_c_q;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            span_q   <= '0;
            zero_a_q <= 1'b0;
            zero_b_q <= 1'b0;
            zero_c_q <= 1'b0;
        end else if (en_i) begin
            addr_q   <= row_offset(ADDR_W'(y_i)) + ADDR_W'(x_i);
            span_q   <= row_offset(ADDR_W'(h_i));
            zero_a_q <= left_i | top_i;
            zero_b_q <= top_i;
            zero_c_q <= left_i;
        end
    end

    assign addr_o   = addr_q;
    assign span_o   = span_q;
    assign zero_a_o = zero_a_q;
    assign zero_b_o = zero_b_q;
    assign zero_c_o = zero_c_q;

endmodule

// File: rtl/ii_window_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// ii_window_fetch_arbiter
//   Shares the single frame_buffer read port between the display address
//   generator (absolute priority, never stalled) and the face-detector window
//   requester. A window request becomes up to four integral-image corner
//   reads issued in display-free cycles (order D, C, B, A) and is returned as
//   one sum D - C - B + A, wrapping modulo 2^DATA_W.
// Ports
//   clk, rst_n         VGA pixel clock, asynchronous active-low reset
//   disp_en_i          display owns the port this cycle
//   disp_addr_i        display read address
//   disp_data_o        display read data (RD_LAT cycles after the address)
//   frame_tick_i       start-of-frame pulse; marks in-flight results stale
//   win_valid_i/ready  window request handshake (ready only when idle)
//   win_x/y/w/h_i      window left column, top row, width, height
//   rd_addr_o          frame_buffer read address
//   rd_data_i          frame_buffer read data
//   sum_valid_o        one-cycle pulse qualifying sum/err/stale
//   sum_o              window sum; zero when err_o is set
//   err_o              request was outside the image or empty
//   stale_o            a frame_tick arrived while the request was in flight
// ----------------------------------------------------------------------------
module ii_window_fetch_arbiter
    import ii_window_fetch_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1  // frame_buffer read latency, 1..3
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_en_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic [DATA_W-1:0] disp_data_o,
    input  logic              frame_tick_i,
    input  logic              win_valid_i,
    output logic              win_ready_o,
    input  logic [7:0]        win_x_i,
    input  logic [6:0]        win_y_i,
    input  logic [7:0]        win_w_i,
    input  logic [6:0]        win_h_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              sum_valid_o,
    output logic [DATA_W-1:0] sum_o,
    output logic              err_o,
    output logic              stale_o
);

    localparam logic [8:0] X_LIMIT = 9'(IMG_W);
    localparam logic [7:0] Y_LIMIT = 8'(IMG_H);

    state_e            state_q;
    logic [7:0]        req_x_q;
    logic [6:0]        req_y_q;
    logic [7:0]        req_w_q;
    logic [6:0]        req_h_q;
    logic [3:0]        issued_q;
    logic              err_pend_q;
    logic              stale_pend_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] corner_q [4];
    tag_t              tag_q    [RD_LAT];
    logic [DATA_W-1:0] sum_q;
    logic              err_q;
    logic              stale_q;
    logic              sum_valid_q;

    // ---------------- CALC: range check and corner D coordinates ----------
    logic [8:0] x_end;
    logic [7:0] y_end;
    logic       req_ok;
    logic [7:0] x1;
    logic [6:0] y1;

    assign x_end  = {1'b0, req_x_q} + {1'b0, req_w_q};
    assign y_end  = {1'b0, req_y_q} + {1'b0, req_h_q};
    assign req_ok = (req_w_q != 8'd0) && (req_h_q != 7'd0) &&
                    (x_end <= X_LIMIT) && (y_end <= Y_LIMIT);
    // Only meaningful when req_ok; truncation on bad requests is harmless.
    assign x1     = x_end[7:0] - 8'd1;
    assign y1     = y_end[6:0] - 7'd1;

    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] span;
    logic              zero_a;
    logic              zero_b;
    logic              zero_c;

    ii_corner_addr u_corner_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q == ST_CALC),
        .x_i      (x1),
        .y_i      (y1),
        .h_i      (req_h_q),
        .left_i   (req_x_q == 8'd0),
        .top_i    (req_y_q == 7'd0),
        .addr_o   (addr_d),
        .span_o   (span),
        .zero_a_o (zero_a),
        .zero_b_o (zero_b),
        .zero_c_o (zero_c)
    );

    // ---------------- ISSUE: pick the next corner to read -----------------
    // The other corners sit a fixed distance from D: one window width to the
    // left (x0 = x1 - w) and/or one window height up (y0 = y1 - h).
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_a;
    logic [3:0]        need;
    logic [3:0]        pending;
    logic [1:0]        cur_idx;
    logic              have_pending;
    logic              more_after;
    logic [ADDR_W-1:0] cur_addr;
    logic              issue_fire;
    logic              inner_busy;

    assign addr_c  = addr_d - ADDR_W'(req_w_q);
    assign addr_b  = addr_d - span;
    assign addr_a  = addr_b - ADDR_W'(req_w_q);
    assign need    = {~zero_a, ~zero_b, ~zero_c, 1'b1};
    assign pending = need & ~issued_q;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cur_idx      = CORNER_D;
        have_pending = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                cur_idx      = 2'(i);
                have_pending = 1'b1;
            end
        end
        more_after = |(pending & ~(4'b0001 << cur_idx));

        case (cur_idx)
            CORNER_D: cur_addr = addr_d;
            CORNER_C: cur_addr = addr_c;
            CORNER_B: cur_addr = addr_b;
            default:  cur_addr = addr_a;
        endcase

        // Tags ahead of the exit stage; the exit stage is captured on the
        // same edge that WAIT hands over to DONE.
        inner_busy = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            inner_busy = inner_busy | tag_q[i].valid;
        end
    end

    assign issue_fire = (state_q == ST_ISSUE) && !disp_en_i && have_pending;

    logic [DATA_W-1:0] corner_sum;
    assign corner_sum = corner_q[CORNER_D] - corner_q[CORNER_C]
                      - corner_q[CORNER_B] + corner_q[CORNER_A];

    // ---------------- FSM, tag pipe and result registers ------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_x_q      <= '0;
            req_y_q      <= '0;
            req_w_q      <= '0;
            req_h_q      <= '0;
            issued_q     <= '0;
            err_pend_q   <= 1'b0;
            stale_pend_q <= 1'b0;
            hold_addr_q  <= '0;
            sum_q        <= '0;
            err_q        <= 1'b0;
            stale_q      <= 1'b0;
            sum_valid_q  <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
            // NOTE: the corner array is small register storage, not a RAM
            // macro, so it is reset with everything else; a mid-request
            // reset therefore leaves no partial sum behind.
            for (int i = 0; i < 4; i++) begin
                corner_q[i] <= '0;
            end
        end else begin
            sum_valid_q <= 1'b0;

            // Tag pipe shifts every cycle; bubbles carry valid=0.
            tag_q[0].valid <= issue_fire;
            tag_q[0].idx   <= cur_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (tag_q[RD_LAT-1].valid) begin
                corner_q[tag_q[RD_LAT-1].idx] <= rd_data_i;
            end

            if (frame_tick_i && (state_q != ST_IDLE)) begin
                stale_pend_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // A tick in the acceptance cycle belongs to the new frame.
                    if (win_valid_i) begin
                        req_x_q      <= win_x_i;
                        req_y_q      <= win_y_i;
                        req_w_q      <= win_w_i;
                        req_h_q      <= win_h_i;
                        issued_q     <= '0;
                        err_pend_q   <= 1'b0;
                        stale_pend_q <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            corner_q[i] <= '0;
                        end
                        state_q      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    err_pend_q <= !req_ok;
                    state_q    <= req_ok ? ST_ISSUE : ST_DONE;
                end
                ST_ISSUE: begin
                    if (issue_fire) begin
                        issued_q[cur_idx] <= 1'b1;
                        hold_addr_q       <= cur_addr;
                        if (!more_after) begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!inner_busy) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    sum_valid_q <= 1'b1;
                    err_q       <= err_pend_q;
                    stale_q     <= stale_pend_q | frame_tick_i;
                    sum_q       <= err_pend_q ? '0 : corner_sum;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Display has the port whenever it asks; otherwise show the corner being
    // issued, or park on the last corner address.
    assign rd_addr_o   = disp_en_i               ? disp_addr_i :
                         (state_q == ST_ISSUE)   ? cur_addr    : hold_addr_q;
    assign disp_data_o = rd_data_i;
    assign win_ready_o = (state_q == ST_IDLE);
    assign sum_valid_o = sum_valid_q;
    assign sum_o       = sum_q;
    assign err_o       = err_q;
    assign stale_o     = stale_q;

endmodule

// File: tb/tb_ii_window_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ii_window_fetch_arbiter
//   Frame buffer holds the all-ones integral image I(x,y) = (x+1)(y+1) with a
//   one-cycle read. Expected results come from the window geometry alone:
//   sum = w*h mod 4096, corner addresses from (x-1, x+w-1, y-1, y+h-1),
//   latency from the count of display-free cycles after acceptance.
// ----------------------------------------------------------------------------
module tb_ii_window_fetch_arbiter;
    import ii_window_fetch_arbiter_pkg::*;

    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_en;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              frame_tick;
    logic              win_valid;
    logic              win_ready;
    logic [7:0]        win_x;
    logic [6:0]        win_y;
    logic [7:0]        win_w;
    logic [6:0]        win_h;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              sum_valid;
    logic [DATA_W-1:0] sum;
    logic              err;
    logic              stale;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ii_window_fetch_arbiter #(.RD_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .disp_en_i    (disp_en),
        .disp_addr_i  (disp_addr),
        .disp_data_o  (disp_data),
        .frame_tick_i (frame_tick),
        .win_valid_i  (win_valid),
        .win_ready_o  (win_ready),
        .win_x_i      (win_x),
        .win_y_i      (win_y),
        .win_w_i      (win_w),
        .win_h_i      (win_h),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .sum_valid_o  (sum_valid),
        .sum_o        (sum),
        .err_o        (err),
        .stale_o      (stale)
    );

    function automatic logic [DATA_W-1:0] ii_val(input logic [ADDR_W-1:0] a);
        int px;
        int py;
        px = int'(a) % IMG_W;
        py = int'(a) / IMG_W;
        return DATA_W'(((px + 1) * (py + 1)) % 4096);
    endfunction

    // Frame buffer port B, one-cycle registered read.
    always @(posedge clk) rd_data <= ii_val(rd_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete request. pat[c] is disp_en during cycle c after the
    // acceptance edge; tick_at is the edge (0 = acceptance) sampling a tick.
    task automatic run_req(input int x, input int y, input int w, input int h,
                           input logic [31:0] pat, input int tick_at, input string name);
        bit   ok;
        int   exp_addr[$];
        int   free_cnt;
        int   k;
        int   lat;
        int   issued;
        bit   exp_stale;
        logic prev_en;
        logic [ADDR_W-1:0] prev_addr;

        ok = (w != 0) && (h != 0) && (x + w <= IMG_W) && (y + h <= IMG_H);
        lat = 2;
        if (ok) begin
            exp_addr.push_back((y + h - 1) * IMG_W + (x + w - 1));                    // D
            if (x > 0)          exp_addr.push_back((y + h - 1) * IMG_W + (x - 1));    // C
            if (y > 0)          exp_addr.push_back((y - 1) * IMG_W + (x + w - 1));    // B
            if (x > 0 && y > 0) exp_addr.push_back((y - 1) * IMG_W + (x - 1));        // A
            free_cnt = 0;
            k = 0;
            for (int c = 1; c < 32 && k == 0; c++) begin
                if (!pat[c]) begin
                    free_cnt++;
                    if (free_cnt == exp_addr.size()) k = c;
                end
            end
            lat = k + LAT + 2;
        end
        exp_stale = (tick_at >= 1) && (tick_at <= lat);

        @(negedge clk);
        check({name, " ready"}, 32'(win_ready), 32'd1);
        win_valid  = 1'b1;
        win_x      = 8'(x);
        win_y      = 7'(y);
        win_w      = 8'(w);
        win_h      = 7'(h);
        disp_en    = 1'b0;
        frame_tick = (tick_at == 0);
        issued     = 0;
        prev_en    = 1'b0;
        prev_addr  = '0;

        for (int c = 0; c <= lat; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                win_valid = 1'b0;
                win_x = 8'($urandom);
                win_y = 7'($urandom);
                win_w = 8'($urandom);
                win_h = 7'($urandom);
            end
            if (prev_en) check({name, " disp_data"}, 32'(disp_data), 32'(ii_val(prev_addr)));
            if (c >= 1) begin
                check({name, " sum_valid"}, 32'(sum_valid), 32'(c == lat));
                check({name, " win_ready"}, 32'(win_ready), 32'(c == lat));
            end
            if (c == lat) begin
                check({name, " sum"},   32'(sum),   ok ? ((w * h) % 4096) : 0);
                check({name, " err"},   32'(err),   32'(!ok));
                check({name, " stale"}, 32'(stale), 32'(exp_stale));
            end else begin
                disp_en    = pat[c];
                disp_addr  = ADDR_W'($urandom_range(0, IMG_W * IMG_H - 1));
                frame_tick = (tick_at == c + 1);
                @(negedge clk);
                if (disp_en) begin
                    check({name, " disp rd_addr"}, 32'(rd_addr), 32'(disp_addr));
                end else if (c >= 1 && issued < exp_addr.size()) begin
                    check({name, " corner rd_addr"}, 32'(rd_addr), exp_addr[issued]);
                    issued++;
                end
                prev_en   = disp_en;
                prev_addr = disp_addr;
            end
        end
        disp_en    = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] pat;
        int rx, ry, rw, rh, rt;

        rst_n      = 1'b0;
        disp_en    = 1'b0;
        disp_addr  = '0;
        frame_tick = 1'b0;
        win_valid  = 1'b0;
        win_x = '0; win_y = '0; win_w = '0; win_h = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst win_ready", 32'(win_ready), 32'd1);
        check("rst sum_valid", 32'(sum_valid), 32'd0);
        check("rst sum",       32'(sum),       32'd0);
        check("rst err",       32'(err),       32'd0);
        check("rst stale",     32'(stale),     32'd0);
        check("rst rd_addr",   32'(rd_addr),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed cases
        run_req(10, 20, 8, 6,   32'h0,                   -1, "t1_basic");
        run_req(0, 0, 4, 4,     32'h0,                   -1, "t2_origin");
        run_req(155, 0, 8, 4,   32'h0,                   -1, "t3_xrange");
        run_req(10, 20, 8, 6,   32'b1_1100,              -1, "t4_contention");
        run_req(10, 20, 8, 6,   32'h0,                    6, "t5_tick_wait");
        run_req(10, 20, 8, 6,   32'h0,                    0, "t5_tick_accept");
        run_req(0, 30, 5, 7,    32'h0,                   -1, "left_edge");
        run_req(40, 0, 9, 3,    32'b1010,                -1, "top_edge");
        run_req(152, 112, 8, 8, 32'h0,                   -1, "max_corner");
        run_req(0, 0, 160, 120, 32'h0,                   -1, "full_image");
        run_req(20, 20, 0, 5,   32'h0,                   -1, "zero_w");
        run_req(20, 20, 5, 0,   32'h0,                   -1, "zero_h");
        run_req(0, 113, 8, 8,   32'h0,                   -1, "yrange");
        run_req(3, 4, 1, 1,     32'h0,                    1, "tick_calc");

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            rx = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 165);
            ry = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 125);
            rw = $urandom_range(0, 40);
            rh = $urandom_range(0, 40);
            pat = '0;
            for (int b = 1; b < 13; b++) begin
                if ($urandom_range(0, 9) < 3) pat[b] = 1'b1;
            end
            rt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : -1;
            run_req(rx, ry, rw, rh, pat, rt, "random");
        end

        // Leave a non-zero, stale result registered, then reset mid-ISSUE.
        run_req(10, 20, 8, 6, 32'h0, 3, "pre_reset");
        @(negedge clk);
        win_valid = 1'b1;
        win_x = 8'd10; win_y = 7'd20; win_w = 8'd8; win_h = 7'd6;
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 win_ready", 32'(win_ready), 32'd1);
        check("t6 sum_valid", 32'(sum_valid), 32'd0);
        check("t6 sum",       32'(sum),       32'd0);
        check("t6 err",       32'(err),       32'd0);
        check("t6 stale",     32'(stale),     32'd0);
        check("t6 rd_addr",   32'(rd_addr),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("t6 no sum_valid", 32'(sum_valid), 32'd0);
        end
        run_req(0, 0, 4, 4, 32'h0, -1, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
